// File: rtl/bru_pkg.sv
// Shared definitions for the branch resolution unit: bru_op bit positions,
// 2-bit direction counter encodings, allocation value and the counter
// update helper. Pure package, no ports, no latency, no backpressure.
package bru_pkg;

   // Bit positions inside the one-hot {jal, jalr, beq, bne, blt, bge, bltu, bgeu} op
   localparam int OP_W    = 8;
   localparam int OP_JAL  = 7;
   localparam int OP_JALR = 6;
   localparam int OP_BEQ  = 5;
   localparam int OP_BNE  = 4;
   localparam int OP_BLT  = 3;
   localparam int OP_BGE  = 2;
   localparam int OP_BLTU = 1;
   localparam int OP_BGEU = 0;

   // 2-bit saturating direction counter; the msb is the taken prediction
   typedef enum logic [1:0] {
      CTR_SNT = 2'd0,
      CTR_WNT = 2'd1,
      CTR_WT  = 2'd2,
      CTR_ST  = 2'd3
   } ctr_t;

   // A fresh entry starts weakly taken so a single not-taken flips it
   localparam ctr_t CTR_ALLOC = CTR_WT;

   // Saturating step toward the observed direction
   function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
      ctr_t nxt;
      nxt = cur;
      if (taken && (cur != CTR_ST)) begin
         nxt = ctr_t'(cur + 2'd1);
      end else if (!taken && (cur != CTR_SNT)) begin
         nxt = ctr_t'(cur - 2'd1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/bru_btb.sv
// Branch target buffer: direct-mapped table of {valid, tag, target, ctr, jmp}.
// Ports: clk/resetn; lookup_pc -> lookup_taken/lookup_target (fetch, 0 cycles);
// probe_pc -> probe_* (execute-side read for training); wr_* single write port.
// Both reads are combinational from registers, so a write is visible only from
// the next cycle. Only the valid bits are reset; payload fields are don't-care
// until their valid bit is set.
module bru_btb
   import bru_pkg::*;
#(
   parameter  int XLEN        = 32,
   parameter  int BTB_ENTRIES = 16,
   localparam int IDX_W       = $clog2(BTB_ENTRIES),
   localparam int TAG_W       = XLEN - 2 - IDX_W
) (
   input  logic             clk,
   input  logic             resetn,
   // fetch lookup
   input  logic [XLEN-1:0]  lookup_pc,
   output logic             lookup_taken,
   output logic [XLEN-1:0]  lookup_target,
   // execute-side probe used to decide the training write
   input  logic [XLEN-1:0]  probe_pc,
   output logic             probe_hit,
   output ctr_t             probe_ctr,
   output logic             probe_jmp,
   output logic [XLEN-1:0]  probe_target,
   // write port
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic [XLEN-1:0]  wr_target,
   input  ctr_t             wr_ctr,
   input  logic             wr_jmp
);

   logic [BTB_ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
   logic [XLEN-1:0]        target_q [BTB_ENTRIES];
   ctr_t                   ctr_q    [BTB_ENTRIES];
   logic                   jmp_q    [BTB_ENTRIES];

   logic [IDX_W-1:0] lookup_idx;
   logic [TAG_W-1:0] lookup_tag;
   logic             lookup_hit;
   logic [IDX_W-1:0] probe_idx;
   logic [TAG_W-1:0] probe_tag;

   // Instructions are word aligned; the two low PC bits never index or tag
   logic unused_pc_lsbs;
   assign unused_pc_lsbs = ^{lookup_pc[1:0], probe_pc[1:0]};

   // ---------------- fetch lookup ----------------
   assign lookup_idx = lookup_pc[IDX_W+1:2];
   assign lookup_tag = lookup_pc[XLEN-1:IDX_W+2];
   assign lookup_hit = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);

   // Unconditional jumps predict taken regardless of the counter
   assign lookup_taken  = lookup_hit && (jmp_q[lookup_idx] || (ctr_q[lookup_idx] >= CTR_WT));
   assign lookup_target = lookup_taken ? target_q[lookup_idx] : '0;

   // ---------------- execute probe ----------------
   assign probe_idx    = probe_pc[IDX_W+1:2];
   assign probe_tag    = probe_pc[XLEN-1:IDX_W+2];
   assign probe_hit    = valid_q[probe_idx] && (tag_q[probe_idx] == probe_tag);
   assign probe_ctr    = ctr_q[probe_idx];
   assign probe_jmp    = jmp_q[probe_idx];
   assign probe_target = target_q[probe_idx];

   // ---------------- table state ----------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_q[wr_idx]    <= wr_tag;
         target_q[wr_idx] <= wr_target;
         ctr_q[wr_idx]    <= wr_ctr;
         jmp_q[wr_idx]    <= wr_jmp;
      end
   end

endmodule

// File: rtl/bru_bp.sv
// Branch resolution unit with integrated BTB and 2-bit direction predictor.
// Ports: clk/resetn; IF lookup (if_pc -> pred_taken/pred_target, 0 cycles);
// EX resolve (ex_* -> link_result comb., redirect_valid/redirect_pc 1 cycle
// later); saturating branch_cnt/mispred_cnt. ex_stall freezes training,
// counting and redirect; input arriving while redirect_valid=1 is wrong-path
// and is dropped.
module bru_bp
   import bru_pkg::*;
#(
   parameter  int XLEN        = 32,
   parameter  int BTB_ENTRIES = 16,
   localparam int IDX_W       = $clog2(BTB_ENTRIES),
   localparam int TAG_W       = XLEN - 2 - IDX_W
) (
   input  logic            clk,
   input  logic            resetn,
   // fetch lookup
   input  logic [XLEN-1:0] if_pc,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   // execute resolve
   input  logic            ex_valid,
   input  logic            ex_stall,
   input  logic [OP_W-1:0] ex_bru_op,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_rdata1,
   input  logic [XLEN-1:0] ex_rdata2,
   input  logic [XLEN-1:0] ex_imm,
   input  logic            ex_pred_taken,
   input  logic [XLEN-1:0] ex_pred_target,
   output logic [XLEN-1:0] link_result,
   // redirect to PC mux / flush
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   // statistics
   output logic [31:0]     branch_cnt,
   output logic [31:0]     mispred_cnt
);

   // ---------------- decode ----------------
   logic is_jal, is_jalr, is_beq, is_bne, is_blt, is_bge, is_bltu, is_bgeu;
   logic is_jump, is_ctrl;

   assign is_jal  = ex_bru_op[OP_JAL];
   assign is_jalr = ex_bru_op[OP_JALR];
   assign is_beq  = ex_bru_op[OP_BEQ];
   assign is_bne  = ex_bru_op[OP_BNE];
   assign is_blt  = ex_bru_op[OP_BLT];
   assign is_bge  = ex_bru_op[OP_BGE];
   assign is_bltu = ex_bru_op[OP_BLTU];
   assign is_bgeu = ex_bru_op[OP_BGEU];
   assign is_jump = is_jal | is_jalr;
   assign is_ctrl = |ex_bru_op;

   // redirect_valid marks the cycle after a mispredict: whatever sits in EX
   // then is already on the wrong path.
   logic resolve;
   assign resolve = ex_valid & ~ex_stall & ~redirect_valid & is_ctrl;

   // ---------------- outcome ----------------
   logic cmp_eq, cmp_lt, cmp_ltu;
   logic actual_taken;

   assign cmp_eq  = (ex_rdata1 == ex_rdata2);
   assign cmp_lt  = ($signed(ex_rdata1) < $signed(ex_rdata2));
   assign cmp_ltu = (ex_rdata1 < ex_rdata2);

   assign actual_taken = is_jump
                       | (is_beq  &  cmp_eq)
                       | (is_bne  & ~cmp_eq)
                       | (is_blt  &  cmp_lt)
                       | (is_bge  & ~cmp_lt)
                       | (is_bltu &  cmp_ltu)
                       | (is_bgeu & ~cmp_ltu);

   logic [XLEN-1:0] pc_rel_target;
   logic [XLEN-1:0] jalr_sum;
   logic [XLEN-1:0] actual_target;
   logic [XLEN-1:0] correct_pc;

   assign link_result   = ex_pc + XLEN'(4);
   assign pc_rel_target = ex_pc + ex_imm;
   assign jalr_sum      = ex_rdata1 + ex_imm;
   // jalr clears bit 0 of the computed address
   assign actual_target = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : pc_rel_target;
   assign correct_pc    = actual_taken ? actual_target : link_result;

   // Target only matters when both sides agree the transfer is taken
   logic mispredict;
   assign mispredict = (actual_taken != ex_pred_taken)
                     | (actual_taken & ex_pred_taken & (actual_target != ex_pred_target));

   // ---------------- BTB and training ----------------
   logic            probe_hit;
   ctr_t            probe_ctr;
   logic            probe_jmp;
   logic [XLEN-1:0] probe_target;

   logic             wr_en;
   logic [IDX_W-1:0] wr_idx;
   logic [TAG_W-1:0] wr_tag;
   logic [XLEN-1:0]  wr_target;
   ctr_t             wr_ctr;
   logic             wr_jmp;

   // Hits always update the counter; misses allocate only when taken, so
   // never-taken branches do not pollute the table.
   assign wr_en     = resolve & (probe_hit | actual_taken);
   assign wr_idx    = ex_pc[IDX_W+1:2];
   assign wr_tag    = ex_pc[XLEN-1:IDX_W+2];
   assign wr_target = actual_taken ? actual_target : probe_target;
   assign wr_ctr    = probe_hit ? ctr_next(probe_ctr, actual_taken) : CTR_ALLOC;
   assign wr_jmp    = probe_hit ? (probe_jmp | is_jump) : is_jump;

   bru_btb #(
      .XLEN        (XLEN),
      .BTB_ENTRIES (BTB_ENTRIES)
   ) u_btb (
      .clk           (clk),
      .resetn        (resetn),
      .lookup_pc     (if_pc),
      .lookup_taken  (pred_taken),
      .lookup_target (pred_target),
      .probe_pc      (ex_pc),
      .probe_hit     (probe_hit),
      .probe_ctr     (probe_ctr),
      .probe_jmp     (probe_jmp),
      .probe_target  (probe_target),
      .wr_en         (wr_en),
      .wr_idx        (wr_idx),
      .wr_tag        (wr_tag),
      .wr_target     (wr_target),
      .wr_ctr        (wr_ctr),
      .wr_jmp        (wr_jmp)
   );

   // ---------------- redirect and statistics ----------------
   logic [31:0] branch_cnt_q;
   logic [31:0] mispred_cnt_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         branch_cnt_q   <= '0;
         mispred_cnt_q  <= '0;
      end else begin
         // Pulse: squashing of the next EX slot keeps this from repeating
         redirect_valid <= resolve & mispredict;
         if (resolve & mispredict) begin
            redirect_pc <= correct_pc;
         end
         if (resolve && (branch_cnt_q != 32'hFFFF_FFFF)) begin
            branch_cnt_q <= branch_cnt_q + 32'd1;
         end
         if (resolve && mispredict && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
            mispred_cnt_q <= mispred_cnt_q + 32'd1;
         end
      end
   end

   assign branch_cnt  = branch_cnt_q;
   assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_bru_bp.sv
// Self-checking bench for bru_bp: table of resolve vectors with expected
// redirect/lookup results, scoreboard queue for redirects, and hand-written
// sequences for same-cycle lookup, squash, stall, reset and saturation.
module tb_bru_bp;

   localparam logic [7:0] JAL  = 8'h80;
   localparam logic [7:0] JALR = 8'h40;
   localparam logic [7:0] BEQ  = 8'h20;
   localparam logic [7:0] BNE  = 8'h10;
   localparam logic [7:0] BLT  = 8'h08;
   localparam logic [7:0] BGE  = 8'h04;
   localparam logic [7:0] BLTU = 8'h02;
   localparam logic [7:0] BGEU = 8'h01;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        ex_valid;
   logic        ex_stall;
   logic [7:0]  ex_bru_op;
   logic [31:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic [31:0] link_result;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] branch_cnt;
   logic [31:0] mispred_cnt;

   bru_bp #(.XLEN(32), .BTB_ENTRIES(16)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .if_pc          (if_pc),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .ex_valid       (ex_valid),
      .ex_stall       (ex_stall),
      .ex_bru_op      (ex_bru_op),
      .ex_pc          (ex_pc),
      .ex_rdata1      (ex_rdata1),
      .ex_rdata2      (ex_rdata2),
      .ex_imm         (ex_imm),
      .ex_pred_taken  (ex_pred_taken),
      .ex_pred_target (ex_pred_target),
      .link_result    (link_result),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .branch_cnt     (branch_cnt),
      .mispred_cnt    (mispred_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [7:0]  op;
      logic [31:0] pc, r1, r2, imm;
      logic        pt;
      logic [31:0] ptgt;
      logic        exp_res;
      logic        exp_rv;
      logic [31:0] exp_rpc;
      logic        exp_pt;
      logic [31:0] exp_ptgt;
   } vec_t;

   typedef struct packed {
      logic        rv;
      logic [31:0] rpc;
   } exp_t;

   vec_t  vecs[12];
   exp_t  exp_q[$];
   int    checks = 0;
   int    errors = 0;
   logic [31:0] exp_br  = 32'd0;
   logic [31:0] exp_mis = 32'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %h required %h", name, act, req);
      end
   endtask

   function automatic vec_t mk(input logic [7:0] op, input logic [31:0] pc, r1, r2, imm,
                               input logic pt, input logic [31:0] ptgt,
                               input logic rv, input logic [31:0] rpc,
                               input logic ept, input logic [31:0] eptgt);
      vec_t v;
      v.valid = 1'b1; v.op = op; v.pc = pc; v.r1 = r1; v.r2 = r2; v.imm = imm;
      v.pt = pt; v.ptgt = ptgt; v.exp_res = |op; v.exp_rv = rv; v.exp_rpc = rpc;
      v.exp_pt = ept; v.exp_ptgt = eptgt;
      return v;
   endfunction

   task automatic drive(input logic valid, input logic [7:0] op, input logic [31:0] pc, r1, r2, imm,
                        input logic pt, input logic [31:0] ptgt);
      ex_valid = valid; ex_bru_op = op; ex_pc = pc; ex_rdata1 = r1; ex_rdata2 = r2;
      ex_imm = imm; ex_pred_taken = pt; ex_pred_target = ptgt;
   endtask

   task automatic idle();
      ex_valid = 1'b0; ex_bru_op = 8'h00; ex_stall = 1'b0;
   endtask

   task automatic bump(input logic mis);
      if (exp_br != 32'hFFFF_FFFF) exp_br = exp_br + 32'd1;
      if (mis && (exp_mis != 32'hFFFF_FFFF)) exp_mis = exp_mis + 32'd1;
   endtask

   task automatic chk_cnt(input string tag);
      chk($sformatf("%s branch_cnt", tag), branch_cnt, exp_br);
      chk($sformatf("%s mispred_cnt", tag), mispred_cnt, exp_mis);
   endtask

   task automatic chk_pred(input string tag, input logic [31:0] pc, input logic ept, input logic [31:0] eptgt);
      if_pc = pc;
      #1;
      chk($sformatf("%s pred_taken", tag), {31'd0, pred_taken}, {31'd0, ept});
      chk($sformatf("%s pred_target", tag), pred_target, eptgt);
   endtask

   // One vector: drive at a negedge, check the redirect one cycle later,
   // check the pulse dropped, then look the PC up.
   task automatic apply(input vec_t v, input string tag);
      exp_t e;
      @(negedge clk);
      drive(v.valid, v.op, v.pc, v.r1, v.r2, v.imm, v.pt, v.ptgt);
      #1;
      chk($sformatf("%s link_result", tag), link_result, v.pc + 32'd4);
      exp_q.push_back('{rv: v.exp_rv, rpc: v.exp_rpc});
      if (v.exp_res) bump(v.exp_rv);
      @(negedge clk);
      idle();
      e = exp_q.pop_front();
      chk($sformatf("%s redirect_valid", tag), {31'd0, redirect_valid}, {31'd0, e.rv});
      if (e.rv) chk($sformatf("%s redirect_pc", tag), redirect_pc, e.rpc);
      chk_cnt(tag);
      @(negedge clk);
      chk($sformatf("%s redirect_drop", tag), {31'd0, redirect_valid}, 32'd0);
      chk_pred(tag, v.pc, v.exp_pt, v.exp_ptgt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;

      //        op    pc            r1            r2            imm           pt    ptgt          rv    rpc           ept   eptgt
      vecs[0]  = mk(BEQ,  32'h100,      32'd5,        32'd5,        32'h40,       1'b0, 32'h0,        1'b1, 32'h140,      1'b1, 32'h140);
      vecs[1]  = mk(BEQ,  32'h100,      32'd5,        32'd6,        32'h40,       1'b1, 32'h140,      1'b1, 32'h104,      1'b0, 32'h0);
      vecs[2]  = mk(BEQ,  32'h100,      32'd5,        32'd6,        32'h40,       1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0);
      vecs[3]  = mk(JALR, 32'h200,      32'h1001,     32'd0,        32'd2,        1'b1, 32'h1000,     1'b1, 32'h1002,     1'b1, 32'h1002);
      vecs[4]  = mk(BLT,  32'h308,      32'hFFFFFFFF, 32'd1,        32'hFFFFFFF8, 1'b0, 32'h0,        1'b1, 32'h300,      1'b1, 32'h300);
      vecs[5]  = mk(BLTU, 32'h30C,      32'hFFFFFFFF, 32'd1,        32'h10,       1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0);
      vecs[6]  = mk(BGE,  32'h310,      32'd1,        32'hFFFFFFFF, 32'h20,       1'b1, 32'h330,      1'b0, 32'h0,        1'b1, 32'h330);
      vecs[7]  = mk(BGEU, 32'h314,      32'd1,        32'hFFFFFFFF, 32'h20,       1'b1, 32'h400,      1'b1, 32'h318,      1'b0, 32'h0);
      vecs[8]  = mk(BNE,  32'h318,      32'd3,        32'd4,        32'h100,      1'b1, 32'h400,      1'b1, 32'h418,      1'b1, 32'h418);
      vecs[9]  = mk(JAL,  32'h31C,      32'd0,        32'd0,        32'hFFFFFF00, 1'b1, 32'h21C,      1'b0, 32'h0,        1'b1, 32'h21C);
      vecs[10] = mk(8'h0, 32'h320,      32'd0,        32'd0,        32'h40,       1'b1, 32'h360,      1'b0, 32'h0,        1'b0, 32'h0);
      vecs[11] = mk(JAL,  32'hFFFFFFFC, 32'd0,        32'd0,        32'd8,        1'b0, 32'h0,        1'b1, 32'h4,        1'b1, 32'h4);

      // ---- reset state ----
      resetn = 1'b0;
      if_pc = 32'h100;
      idle();
      drive(1'b0, 8'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      chk_pred("reset", 32'h100, 1'b0, 32'h0);
      chk("reset redirect_valid", {31'd0, redirect_valid}, 32'd0);
      chk("reset redirect_pc", redirect_pc, 32'h0);
      chk_cnt("reset");

      // ---- table-driven vectors ----
      for (int i = 0; i < 12; i++) apply(vecs[i], $sformatf("v%0d", i));

      // ---- same-cycle lookup/update, then wrong-path squash ----
      @(negedge clk);
      if_pc = 32'h318;
      drive(1'b1, BNE, 32'h318, 32'd3, 32'd4, 32'h200, 1'b1, 32'h418);
      #1;
      chk("same_cycle pred_taken", {31'd0, pred_taken}, 32'd1);
      chk("same_cycle pred_target", pred_target, 32'h418);
      exp_q.push_back('{rv: 1'b1, rpc: 32'h518});
      bump(1'b1);
      @(negedge clk);
      e = exp_q.pop_front();
      chk("same_cycle redirect_valid", {31'd0, redirect_valid}, {31'd0, e.rv});
      chk("same_cycle redirect_pc", redirect_pc, e.rpc);
      #1;
      chk("next_cycle pred_target", pred_target, 32'h518);
      drive(1'b1, BEQ, 32'h324, 32'd7, 32'd7, 32'h40, 1'b0, 32'h0);
      exp_q.push_back('{rv: 1'b0, rpc: 32'h0});
      @(negedge clk);
      e = exp_q.pop_front();
      chk("squash redirect_valid", {31'd0, redirect_valid}, {31'd0, e.rv});
      chk_cnt("squash");
      idle();
      chk_pred("squash", 32'h324, 1'b0, 32'h0);

      // ---- stall holds state; stall does not stretch the pulse ----
      @(negedge clk);
      drive(1'b1, BEQ, 32'h328, 32'd9, 32'd9, 32'h40, 1'b0, 32'h0);
      ex_stall = 1'b1;
      exp_q.push_back('{rv: 1'b0, rpc: 32'h0});
      @(negedge clk);
      e = exp_q.pop_front();
      chk("stall redirect_valid", {31'd0, redirect_valid}, {31'd0, e.rv});
      chk_cnt("stall");
      chk_pred("stall", 32'h328, 1'b0, 32'h0);
      ex_stall = 1'b0;
      exp_q.push_back('{rv: 1'b1, rpc: 32'h368});
      bump(1'b1);
      @(negedge clk);
      e = exp_q.pop_front();
      chk("unstall redirect_valid", {31'd0, redirect_valid}, {31'd0, e.rv});
      chk("unstall redirect_pc", redirect_pc, e.rpc);
      ex_stall = 1'b1;
      @(negedge clk);
      chk("stall_pulse redirect_valid", {31'd0, redirect_valid}, 32'd0);
      chk_cnt("stall_pulse");
      idle();

      // ---- fill eight entries with correctly predicted jumps ----
      for (int i = 0; i < 8; i++) begin
         logic [31:0] pc;
         pc = 32'h600 + 32'(4 * i);
         apply(mk(JAL, pc, 32'd0, 32'd0, 32'h10, 1'b1, pc + 32'h10, 1'b0, 32'h0, 1'b1, pc + 32'h10),
               $sformatf("fill%0d", i));
      end

      // ---- asynchronous reset mid-run ----
      @(negedge clk);
      #2 resetn = 1'b0;
      exp_br = 32'd0;
      exp_mis = 32'd0;
      for (int i = 0; i < 8; i++) begin
         chk_pred($sformatf("arst%0d", i), 32'h600 + 32'(4 * i), 1'b0, 32'h0);
      end
      chk("arst redirect_valid", {31'd0, redirect_valid}, 32'd0);
      chk("arst redirect_pc", redirect_pc, 32'h0);
      chk_cnt("arst");
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      chk_pred("post_arst", 32'h604, 1'b0, 32'h0);
      chk_cnt("post_arst");

      // ---- counter saturation ----
      @(negedge clk);
      force dut.branch_cnt_q  = 32'hFFFF_FFFE;
      force dut.mispred_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.branch_cnt_q;
      release dut.mispred_cnt_q;
      #1;
      exp_br  = 32'hFFFF_FFFE;
      exp_mis = 32'hFFFF_FFFE;
      chk_cnt("preset");
      apply(mk(JAL, 32'h700, 32'd0, 32'd0, 32'h10, 1'b0, 32'h0, 1'b1, 32'h710, 1'b1, 32'h710), "sat0");
      apply(mk(JAL, 32'h704, 32'd0, 32'd0, 32'h10, 1'b0, 32'h0, 1'b1, 32'h714, 1'b1, 32'h714), "sat1");
      apply(mk(BNE, 32'h708, 32'd1, 32'd2, 32'h10, 1'b1, 32'h718, 1'b0, 32'h0, 1'b1, 32'h718), "sat2");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bru_bp.md
# bru_bp

Branch resolution unit with an integrated branch target buffer (BTB) and 2-bit direction predictor. It is the parametrised successor to the combinational branch unit.
- The fetch stage queries it every cycle for a predicted next PC.
- The execute stage presents each resolved control-transfer instruction. The unit compares the outcome with the prediction carried down the pipe, trains the table, and issues a registered redirect on mispredict.
- It sits between IF (lookup port) and EX (resolve port). The redirect feeds the PC mux and pipeline flush.

## Interface
- XLEN, 32, datapath and PC width
- BTB_ENTRIES, 16, table depth; power of two, ≥2
- IDX_W, $clog2(BTB_ENTRIES), derived index width
- TAG_W, XLEN-2-IDX_W, derived tag width

- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- if_pc  in  XLEN  fetch PC to look up
- pred_taken  out  1  prediction for if_pc; combinational from registered table
- pred_target  out  XLEN  predicted target; 0 when pred_taken=0
- ex_valid  in  1  resolve port carries a real instruction
- ex_stall  in  1  EX held this cycle; no training, no counting, no redirect
- ex_bru_op  in  8  one-hot {jal, jalr, beq, bne, blt, bge, bltu, bgeu}; all-zero = not a control transfer
- ex_pc, ex_rdata1, ex_rdata2, ex_imm  in  XLEN each  instruction PC, rs1, rs2, sign-extended immediate
- ex_pred_taken  in  1  prediction made for ex_pc at fetch
- ex_pred_target  in  XLEN  predicted target made for ex_pc at fetch
- link_result  out  XLEN  ex_pc+4; combinational; rd value for jal/jalr
- redirect_valid  out  1  registered mispredict redirect
- redirect_pc  out  XLEN  registered correct next PC
- branch_cnt  out  32  resolved control transfers, saturating
- mispred_cnt  out  32  mispredicts, saturating

## Operation
**Resolve condition**
- An instruction resolves when ex_valid & ~ex_stall & ~redirect_valid & (|ex_bru_op).
- ex_valid in a cycle where redirect_valid=1 is a wrong-path instruction and is ignored entirely.

**Actual outcome**
- beq/bne: equality compare. blt/bge: signed compare. bltu/bgeu: unsigned compare. jal/jalr: always taken.
- Target is ex_pc+ex_imm, except jalr, whose target is (ex_rdata1+ex_imm) & ~1.
- All adds wrap modulo 2^XLEN.

**Mispredict**
- A mispredict is any of:
  - actual_taken ≠ ex_pred_taken
  - actual_taken & ex_pred_taken & (target ≠ ex_pred_target)
- Correct next PC = actual_taken ? target : ex_pc+4.

**BTB entry and lookup**
- Entry fields: valid, tag, target, ctr[1:0], jmp.
- Index = pc[IDX_W+1:2]. Tag = pc[XLEN-1:IDX_W+2].
- Lookup hit = valid & tag match.
- pred_taken = hit & (jmp | ctr[1]).

**Training (on resolve)**
- Hit:
  - ctr increments when taken and decrements when not taken, saturating at 3 and 0.
  - If taken, target is overwritten.
  - jmp is set for jal/jalr.
- Miss and taken: allocate the entry, overwriting any victim. Fields: valid=1, tag, target, ctr=2 (weak taken), jmp per op.
- Miss and not taken: no write.

**Counters**
- branch_cnt increments on every resolve.
- mispred_cnt increments on every resolve that mispredicts.
- Both stick at 32'hFFFFFFFF.

## Timing
**Latency**
- Lookup: 0 cycles. Same-cycle combinational read.
- Redirect: 1 cycle. A mispredict resolved in cycle N gives redirect_valid=1 and redirect_pc in cycle N+1.
- redirect_valid is a single-cycle pulse unless the following resolve also mispredicts. That cannot happen, because wrong-path input is squashed, so back-to-back pulses never occur.

**Reset**
- Asynchronous on resetn=0, also mid-operation.
- All valid bits, redirect_valid, redirect_pc, branch_cnt and mispred_cnt clear to 0.
- With all valid bits clear, pred_taken=0 and pred_target=0 immediately.

**Boundary conditions**
- Lookup and update hitting the same index in one cycle: lookup returns pre-update contents. The write is visible from the next cycle.
- ex_stall=1 holds all state. redirect_valid still drops after its one pulse.
- A non-control op with ex_valid=1 causes no training, no counting and no redirect.

## Structure
**Shared package bru_pkg**
- Bit positions of bru_op fields.
- Counter encodings: SNT=0, WNT=1, WT=2, ST=3.
- Reset-allocation value WT.

**Sub-module bru_btb**
- Holds the table registers and the lookup logic.
- Write port: en, idx, tag, target, ctr, jmp.
- Parametrised by XLEN and BTB_ENTRIES.
- Compare, outcome, training decision, redirect register and counters live in bru_bp.

## Test plan
1. Reset, then look up if_pc=0x100. Required: pred_taken=0, pred_target=0, all outputs 0.
2. beq at ex_pc=0x100, imm=0x40, rdata1=rdata2=5, ex_pred_taken=0. Next cycle: redirect_valid=1, redirect_pc=0x140. Then if_pc=0x100 gives pred_taken=1, pred_target=0x140. mispred_cnt=1.
3. Same beq resolved not taken twice, with prediction matching the state each time. First resolve: ctr 2→1, pred_taken goes to 0, one redirect to 0x104. Second resolve: ctr→0, no redirect.
4. jalr at ex_pc=0x200, rdata1=0x1001, imm=2, ex_pred_taken=1, ex_pred_target=0x1000. Required: redirect_pc=0x1002, link_result=0x204. Entry is updated to target 0x1002 with jmp=1.
5. Mispredict in cycle N, with another valid beq presented in N+1. Required: the N+1 instruction is ignored (no counter change, no training, no redirect in N+2).
6. Pulse resetn low mid-run with 8 entries valid. Required: pred_taken=0 for all PCs, counters read 0. Also force branch_cnt to saturate and confirm it stays at 0xFFFFFFFF.
